// File: rtl/sccb_pkg.sv
// Shared SCCB write-master definitions: FSM states, phase lengths, table end marker
// and the NACK retry limit.
package sccb_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StStart,
    StBits,
    StStop,
    StAdv,
    StSettle,
    StDone
  } sccb_state_e;

  localparam int unsigned START_Q        = 2;
  localparam int unsigned BIT_Q          = 4;
  localparam int unsigned STOP_Q         = 4;
  localparam int unsigned NUM_BITS       = 27;
  localparam int unsigned NUM_PHASES     = 3;
  localparam logic [15:0] END_MARKER     = 16'hFFFF;
  localparam int unsigned MAX_NACK_RETRY = 3;

endpackage

// File: rtl/sccb_tick_gen.sv
// Quarter-bit tick generator: pulses tick for one cycle every CLK_DIV enabled cycles.
module sccb_tick_gen #(
  parameter int unsigned CLK_DIV = 250
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic tick
);

  localparam int unsigned CntW = $clog2(CLK_DIV);
  localparam logic [CntW-1:0] CntLast = CntW'(CLK_DIV - 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  always_comb begin
    tick  = enable && (cnt_q == CntLast);
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (enable) begin
      cnt_d = tick ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/sccb_write_master.sv
// SCCB (OV7670) register-table write master: sends {DEVICE_ID, addr, data} per table
// entry, then idles SETTLE_CYCLES. Optional ACK checking/retry under SCCB_ACK_CHECK_EN.
module sccb_write_master
  import sccb_pkg::*;
#(
  parameter int unsigned CLK_DIV       = 250,
  parameter logic [7:0]  DEVICE_ID     = 8'h42,
  parameter int unsigned SETTLE_CYCLES = 100000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] control,
  input  logic        finished,
  output logic        advance,
  output logic        sioc,
  output logic        siod_out,
  output logic        siod_oe,
  output logic        busy,
  output logic        config_done
`ifdef SCCB_ACK_CHECK_EN
  ,
  input  logic        siod_in,
  output logic        nack_err
`endif
);

  localparam logic [1:0] QStartLast   = 2'(START_Q - 1);
  localparam logic [1:0] QBitLast     = 2'(BIT_Q - 1);
  localparam logic [1:0] QStopLast    = 2'(STOP_Q - 1);
  localparam int unsigned BitsPerPhase = NUM_BITS / NUM_PHASES;
  localparam logic [3:0] BitLast      = 4'(BitsPerPhase - 1);
  localparam logic [1:0] PhaseLast    = 2'(NUM_PHASES - 1);
  localparam int unsigned SettleW     = $clog2(SETTLE_CYCLES + 1);
  localparam logic [SettleW-1:0] SettleLast = SettleW'(SETTLE_CYCLES - 1);

  sccb_state_e        state_q, state_d;
  logic [1:0]         qtr_q, qtr_d;
  logic [3:0]         bit_q, bit_d;
  logic [1:0]         byte_q, byte_d;
  logic [23:0]        frame_q, frame_d;
  logic [SettleW-1:0] settle_q, settle_d;
  logic               tick;
  logic [23:0]        frame_sh;

`ifdef SCCB_ACK_CHECK_EN
  logic       nack_q, nack_d;
  logic [1:0] retry_q, retry_d;
  logic       nack_err_q, nack_err_d;
  localparam logic [1:0] RetryLast = 2'(MAX_NACK_RETRY - 1);
  assign nack_err = nack_err_q;
`endif

  sccb_tick_gen #(
    .CLK_DIV(CLK_DIV)
  ) u_tick_gen (
    .clk   (clk),
    .rst_n (rst_n),
    .clear ((state_q == StLoad) || (state_q == StAdv)),
    .enable((state_q != StIdle) && (state_q != StDone)),
    .tick  (tick)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      qtr_q    <= '0;
      bit_q    <= '0;
      byte_q   <= '0;
      frame_q  <= '0;
      settle_q <= '0;
`ifdef SCCB_ACK_CHECK_EN
      nack_q     <= 1'b0;
      retry_q    <= '0;
      nack_err_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      qtr_q    <= qtr_d;
      bit_q    <= bit_d;
      byte_q   <= byte_d;
      frame_q  <= frame_d;
      settle_q <= settle_d;
`ifdef SCCB_ACK_CHECK_EN
      nack_q     <= nack_d;
      retry_q    <= retry_d;
      nack_err_q <= nack_err_d;
`endif
    end
  end

  always_comb begin
    state_d  = state_q;
    qtr_d    = qtr_q;
    bit_d    = bit_q;
    byte_d   = byte_q;
    frame_d  = frame_q;
    settle_d = settle_q;
`ifdef SCCB_ACK_CHECK_EN
    nack_d     = nack_q;
    retry_d    = retry_q;
    nack_err_d = nack_err_q;
`endif
    unique case (state_q)
      StIdle: state_d = finished ? StDone : StLoad;
      StLoad: begin
        frame_d = {DEVICE_ID, control};
        qtr_d   = '0;
        bit_d   = '0;
        byte_d  = '0;
`ifdef SCCB_ACK_CHECK_EN
        nack_d  = 1'b0;
        retry_d = '0;
`endif
        state_d = StStart;
      end
      StStart: if (tick) begin
        if (qtr_q == QStartLast) begin
          qtr_d   = '0;
          state_d = StBits;
        end else begin
          qtr_d = qtr_q + 2'd1;
        end
      end
      StBits: if (tick) begin
        qtr_d = qtr_q + 2'd1;
        if (qtr_q == QBitLast) begin
          qtr_d = '0;
          if (bit_q == BitLast) begin
            bit_d = '0;
            if (byte_q == PhaseLast) begin
              state_d = StStop;
            end else begin
              byte_d = byte_q + 2'd1;
            end
          end else begin
            bit_d = bit_q + 4'd1;
          end
        end
`ifdef SCCB_ACK_CHECK_EN
        // NACK on the 9th bit aborts the rest of the frame.
        if ((bit_q == BitLast) && (qtr_q == 2'd2) && siod_in) begin
          nack_d  = 1'b1;
          qtr_d   = '0;
          bit_d   = '0;
          state_d = StStop;
        end
`endif
      end
      StStop: if (tick) begin
        if (qtr_q == QStopLast) begin
          qtr_d   = '0;
          state_d = StAdv;
`ifdef SCCB_ACK_CHECK_EN
          if (nack_q) begin
            nack_d = 1'b0;
            byte_d = '0;
            bit_d  = '0;
            if (retry_q == RetryLast) begin
              nack_err_d = 1'b1;
              retry_d    = '0;
            end else begin
              retry_d = retry_q + 2'd1;
              state_d = StStart;
            end
          end
`endif
        end else begin
          qtr_d = qtr_q + 2'd1;
        end
      end
      StAdv: begin
        settle_d = '0;
        state_d  = StSettle;
      end
      StSettle: begin
        if (settle_q == SettleLast) begin
          state_d = StIdle;
        end else begin
          settle_d = settle_q + 1'b1;
        end
      end
      StDone: state_d = StDone;
      default: state_d = StIdle;
    endcase
  end

  assign frame_sh = frame_q << ({byte_q, 3'b000} + {1'b0, bit_q});

  always_comb begin
    sioc        = 1'b1;
    siod_out    = 1'b1;
    siod_oe     = 1'b0;
    busy        = 1'b1;
    advance     = 1'b0;
    config_done = 1'b0;
    unique case (state_q)
      StIdle: busy = 1'b0;
      StStart: begin
        siod_oe  = 1'b1;
        siod_out = (qtr_q == 2'd0);
      end
      StBits: begin
        sioc     = qtr_q[1];
        siod_oe  = (bit_q != BitLast);
        siod_out = (bit_q != BitLast) ? frame_sh[23] : 1'b1;
      end
      StStop: begin
        sioc     = (qtr_q != 2'd0);
        siod_oe  = (qtr_q != 2'd3);
        siod_out = qtr_q[1];
      end
      StAdv: advance = 1'b1;
      StDone: begin
        busy        = 1'b0;
        config_done = 1'b1;
      end
      default: ;
    endcase
  end

endmodule
